// File: rtl/th_ifetch_mem_if.sv
// Fetch-side and RAM-side signal bundle for th_ifetch_mem.
// Fetch handshake: a request transfers in any cycle where i_read_i and
// i_rack_o are both high (i_rack_o is combinational from i_read_i).
// i_ready_o is a one-cycle, unthrottled response pulse, qualified by i_err_o.
// RAM side: a read issues when ram_en_o is high. ram_en_o is only raised
// while ram_gnt_i is high. ram_data_i is sampled one cycle later.
interface th_ifetch_mem_if #(
  parameter int ADDRESS = 28,
  parameter int RAMAW   = 9,
  parameter int DEPTH   = 4
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic               i_read_i;
  logic               i_rack_o;
  logic [ADDRESS-1:0] i_addr_i;
  logic               i_ready_o;
  logic [31:0]        i_data_o;
  logic               i_err_o;
  logic               flush_i;
  logic               ram_gnt_i;
  logic               ram_en_o;
  logic [RAMAW-1:0]   ram_addr_o;
  logic [31:0]        ram_data_i;
  logic [LW-1:0]      q_level_o;

  // Fetch unit plus RAM arbiter side (the environment).
  modport master (
    output i_read_i, i_addr_i, flush_i, ram_gnt_i, ram_data_i,
    input  i_rack_o, i_ready_o, i_data_o, i_err_o, ram_en_o, ram_addr_o, q_level_o
  );

  // The fetch-memory block itself.
  modport slave (
    input  i_read_i, i_addr_i, flush_i, ram_gnt_i, ram_data_i,
    output i_rack_o, i_ready_o, i_data_o, i_err_o, ram_en_o, ram_addr_o, q_level_o
  );
endinterface

// File: rtl/th_ifetch_mem.sv
// Instruction-fetch front end to a shared synchronous block RAM.
// Accepted requests are queued in order and issued when the RAM port is
// granted. An empty queue lets a request bypass straight to the RAM in the
// same cycle. Out-of-range addresses still take their slot in order, but
// they return zero with an error flag.
module th_ifetch_mem #(
  parameter int ADDRESS = 28,
  parameter int RAMAW   = 9,
  parameter int DEPTH   = 4
) (
  input  logic clock_i,
  input  logic reset_ni,
  th_ifetch_mem_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  // Each queue entry holds {out_of_range, ram_word_address}.
  logic [RAMAW:0]   r_q_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [LW-1:0]    r_level;
  logic             r_pend;
  logic             r_pend_oor;

  logic             w_in_oor;
  logic             w_empty;
  logic             w_full;
  logic             w_req;
  logic             w_pop;
  logic             w_bypass;
  logic             w_accept;
  logic             w_push;
  logic [RAMAW:0]   w_head;
  logic [RAMAW-1:0] w_issue_addr;
  logic             w_issue_oor;

  // Request decode, issue selection and acceptance. All of this is gated by
  // reset so that nothing is accepted or issued while reset is held.
  always_comb begin
    w_in_oor     = |bus.i_addr_i[ADDRESS-1:RAMAW];
    w_empty      = (r_level == '0);
    w_full       = r_level[PW];
    w_req        = reset_ni & bus.i_read_i & ~bus.flush_i;
    w_pop        = reset_ni & bus.ram_gnt_i & ~w_empty;
    w_bypass     = reset_ni & bus.ram_gnt_i & w_empty & w_req;
    // A full queue still accepts a request when the head pops in the same cycle.
    w_accept     = w_req & (~w_full | w_pop);
    w_push       = w_accept & ~w_bypass;
    w_head       = r_q_mem[r_rd_ptr];
    w_issue_addr = w_head[RAMAW-1:0];
    w_issue_oor  = w_head[RAMAW];
    if (w_bypass) begin
      w_issue_addr = bus.i_addr_i[RAMAW-1:0];
      w_issue_oor  = w_in_oor;
    end
  end

  assign bus.i_rack_o   = w_accept;
  assign bus.ram_en_o   = w_pop | w_bypass;
  assign bus.ram_addr_o = w_issue_addr;
  assign bus.q_level_o  = r_level;

  // Queue storage. It has no reset; validity is tracked by the pointers and the level.
  always_ff @(posedge clock_i) begin
    if (w_push) begin
      r_q_mem[r_wr_ptr] <= {w_in_oor, bus.i_addr_i[RAMAW-1:0]};
    end
  end

  // Queue pointers and level. A flush discards every unissued entry.
  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else if (bus.flush_i) begin
      r_rd_ptr <= r_wr_ptr;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      r_level <= r_level + LW'(w_push) - LW'(w_pop);
    end
  end

  // Track the read issued last cycle so that its response lines up with the RAM data.
  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_pend     <= 1'b0;
      r_pend_oor <= 1'b0;
    end else begin
      r_pend     <= bus.ram_en_o;
      r_pend_oor <= w_issue_oor;
    end
  end

  assign bus.i_ready_o = r_pend;
  assign bus.i_err_o   = r_pend & r_pend_oor;
  assign bus.i_data_o  = (r_pend && !r_pend_oor) ? bus.ram_data_i : 32'h0;
endmodule
